// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the two-player score controller.
package scoreboard_pkg;

    localparam int unsigned SCORE_W       = 7;
    localparam int unsigned DEF_MAX_SCORE = 99;
    localparam int unsigned DEF_WIN_SCORE = 21;

    typedef enum logic {
        ST_PLAY = 1'b0,
        ST_OVER = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_A    = 2'b01,
        WIN_B    = 2'b10
    } winner_e;

    typedef enum logic {
        PLR_A = 1'b0,
        PLR_B = 1'b1
    } player_e;

    typedef struct packed {
        logic    valid;
        player_e player;
        logic    up;
    } grant_t;

    // One saturating +1/-1 step within 0..max_s.
    function automatic logic [SCORE_W-1:0] sat_step(input logic [SCORE_W-1:0] s,
                                                    input logic               up,
                                                    input logic [SCORE_W-1:0] max_s);
        if (up) begin
            return (s >= max_s) ? s : s + SCORE_W'(1);
        end
        return (s == '0) ? s : s - SCORE_W'(1);
    endfunction

endpackage

// File: rtl/score_rr_arbiter.sv
// Round-robin arbiter merging both players' up/down pulses onto one grant per cycle;
// a losing request is parked in a one-deep pending slot where the newest op wins.
module score_rr_arbiter
    import scoreboard_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_n_i,
    input  logic   en_i,
    input  logic   clear_i,
    input  logic   up_a_i,
    input  logic   down_a_i,
    input  logic   up_b_i,
    input  logic   down_b_i,
    output grant_t grant_c_o
);

    logic    pend_a_q, pend_a_d, pop_a_q, pop_a_d;
    logic    pend_b_q, pend_b_d, pop_b_q, pop_b_d;
    player_e last_q, last_d;
    logic    new_a, new_b, req_a, req_b, op_a, op_b;

    always_comb begin
        new_a     = up_a_i ^ down_a_i;
        new_b     = up_b_i ^ down_b_i;
        req_a     = pend_a_q | new_a;
        req_b     = pend_b_q | new_b;
        op_a      = new_a ? up_a_i : pop_a_q;
        op_b      = new_b ? up_b_i : pop_b_q;
        grant_c_o = '0;
        pend_a_d  = 1'b0;
        pend_b_d  = 1'b0;
        pop_a_d   = pop_a_q;
        pop_b_d   = pop_b_q;
        last_d    = last_q;

        if (clear_i) begin
            last_d = PLR_B;
        end else if (en_i) begin
            // A wins a conflict only when B was the last one served.
            if (req_a && (!req_b || last_q == PLR_B)) begin
                grant_c_o.valid  = 1'b1;
                grant_c_o.player = PLR_A;
                grant_c_o.up     = op_a;
            end else if (req_b) begin
                grant_c_o.valid  = 1'b1;
                grant_c_o.player = PLR_B;
                grant_c_o.up     = op_b;
            end
            if (grant_c_o.valid) begin
                last_d = grant_c_o.player;
            end
            pend_a_d = req_a && !(grant_c_o.valid && grant_c_o.player == PLR_A);
            pend_b_d = req_b && !(grant_c_o.valid && grant_c_o.player == PLR_B);
            if (new_a) pop_a_d = up_a_i;
            if (new_b) pop_b_d = up_b_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            pop_a_q  <= 1'b0;
            pop_b_q  <= 1'b0;
            last_q   <= PLR_B;
        end else begin
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            pop_a_q  <= pop_a_d;
            pop_b_q  <= pop_b_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: rtl/scoreboard_ctrl.sv
// Two-player score controller: saturating scores, win detection and scheduling
// of which score the shared two-digit display shows.
module scoreboard_ctrl
    import scoreboard_pkg::*;
#(
    parameter int unsigned MAX_SCORE   = DEF_MAX_SCORE,
    parameter int unsigned WIN_SCORE   = DEF_WIN_SCORE,
    parameter int unsigned DISP_PERIOD = 2000
) (
    input  logic               clk_1khz_i,
    input  logic               rst_n_i,
    input  logic               up_a_i,
    input  logic               down_a_i,
    input  logic               up_b_i,
    input  logic               down_b_i,
    input  logic               clear_i,
    output logic [SCORE_W-1:0] score_a_o,
    output logic [SCORE_W-1:0] score_b_o,
    output logic [SCORE_W-1:0] disp_value_o,
    output logic               disp_sel_o,
    output logic [1:0]         winner_o,
    output logic               game_over_o
);

    localparam int unsigned TMR_W = (DISP_PERIOD > 1) ? $clog2(DISP_PERIOD) : 1;

    state_e             state_q, state_d;
    winner_e            winner_q, winner_d;
    logic [SCORE_W-1:0] score_a_q, score_a_d, score_b_q, score_b_d;
    logic [SCORE_W-1:0] gscore, stepped;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               sel_q, sel_d;
    grant_t             grant;

    score_rr_arbiter u_arb (
        .clk_i     (clk_1khz_i),
        .rst_n_i   (rst_n_i),
        .en_i      (state_q == ST_PLAY),
        .clear_i   (clear_i),
        .up_a_i    (up_a_i),
        .down_a_i  (down_a_i),
        .up_b_i    (up_b_i),
        .down_b_i  (down_b_i),
        .grant_c_o (grant)
    );

    // Next-state, score update and display scheduling.
    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        score_a_d = score_a_q;
        score_b_d = score_b_q;
        timer_d   = timer_q;
        sel_d     = sel_q;
        gscore    = (grant.player == PLR_B) ? score_b_q : score_a_q;
        stepped   = sat_step(gscore, grant.up, SCORE_W'(MAX_SCORE));

        if (clear_i) begin
            state_d   = ST_PLAY;
            winner_d  = WIN_NONE;
            score_a_d = '0;
            score_b_d = '0;
            timer_d   = '0;
            sel_d     = 1'b0;
        end else if (state_q == ST_OVER) begin
            timer_d = '0;
        end else if (grant.valid) begin
            if (grant.player == PLR_B) score_b_d = stepped;
            else                       score_a_d = stepped;
            sel_d   = (grant.player == PLR_B);
            timer_d = '0;
            if (grant.up && stepped == SCORE_W'(WIN_SCORE)) begin
                state_d  = ST_OVER;
                winner_d = (grant.player == PLR_B) ? WIN_B : WIN_A;
            end
        end else if (timer_q == TMR_W'(DISP_PERIOD - 1)) begin
            timer_d = '0;
            sel_d   = ~sel_q;
        end else begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk_1khz_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_PLAY;
            winner_q  <= WIN_NONE;
            score_a_q <= '0;
            score_b_q <= '0;
            timer_q   <= '0;
            sel_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            score_a_q <= score_a_d;
            score_b_q <= score_b_d;
            timer_q   <= timer_d;
            sel_q     <= sel_d;
        end
    end

    assign score_a_o    = score_a_q;
    assign score_b_o    = score_b_q;
    assign disp_sel_o   = sel_q;
    assign winner_o     = winner_q;
    assign game_over_o  = (state_q == ST_OVER);
    assign disp_value_o = sel_q ? score_b_q : score_a_q;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Bench for scoreboard_ctrl: directed scenarios then random play, every cycle
// compared against an array-based model of the scoring rules.
module tb_scoreboard_ctrl;

    localparam int DP   = 12;
    localparam int MAXS = 99;
    localparam int WINS = 21;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       up_a, down_a, up_b, down_b, clear;
    logic [6:0] score_a, score_b, disp_value;
    logic       disp_sel, game_over;
    logic [1:0] winner;

    int total = 0;
    int bad   = 0;

    int m_sc[2];
    bit m_pend[2];
    bit m_pop[2];
    int m_last, m_sel, m_tmr, m_win;
    bit m_over;

    scoreboard_ctrl #(.MAX_SCORE(MAXS), .WIN_SCORE(WINS), .DISP_PERIOD(DP)) dut (
        .clk_1khz_i   (clk),
        .rst_n_i      (rst_n),
        .up_a_i       (up_a),
        .down_a_i     (down_a),
        .up_b_i       (up_b),
        .down_b_i     (down_b),
        .clear_i      (clear),
        .score_a_o    (score_a),
        .score_b_o    (score_b),
        .disp_value_o (disp_value),
        .disp_sel_o   (disp_sel),
        .winner_o     (winner),
        .game_over_o  (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("score_a", 8'(score_a), 8'(m_sc[0]));
        chk("score_b", 8'(score_b), 8'(m_sc[1]));
        chk("disp_sel", 8'(disp_sel), 8'(m_sel));
        chk("disp_value", 8'(disp_value), 8'(m_sel != 0 ? m_sc[1] : m_sc[0]));
        chk("winner", 8'(winner), 8'(m_win));
        chk("game_over", 8'(game_over), 8'(m_over));
    endtask

    function automatic void mdl_reset();
        m_sc[0] = 0; m_sc[1] = 0;
        m_pend[0] = 0; m_pend[1] = 0;
        m_pop[0] = 0; m_pop[1] = 0;
        m_last = 1; m_sel = 0; m_tmr = 0; m_win = 0; m_over = 0;
    endfunction

    function automatic void mdl_edge(bit ua, bit da, bit ub, bit db, bit clr);
        bit up[2], dn[2], nw[2], req[2], op[2];
        int g;
        if (clr) begin
            m_sc[0] = 0; m_sc[1] = 0;
            m_pend[0] = 0; m_pend[1] = 0;
            m_last = 1; m_tmr = 0; m_sel = 0; m_win = 0; m_over = 0;
            return;
        end
        if (m_over) begin
            m_pend[0] = 0; m_pend[1] = 0; m_tmr = 0;
            return;
        end
        up[0] = ua; dn[0] = da; up[1] = ub; dn[1] = db;
        for (int p = 0; p < 2; p++) begin
            nw[p]  = up[p] != dn[p];
            req[p] = m_pend[p] || nw[p];
            op[p]  = nw[p] ? up[p] : m_pop[p];
        end
        if (req[0] && req[1]) g = (m_last == 1) ? 0 : 1;
        else if (req[0])      g = 0;
        else if (req[1])      g = 1;
        else                  g = -1;
        for (int p = 0; p < 2; p++) begin
            if (p == g) m_pend[p] = 0;
            else if (req[p]) m_pend[p] = 1;
            if (nw[p]) m_pop[p] = up[p];
        end
        if (g >= 0) begin
            m_last = g;
            if (op[g]) m_sc[g] = (m_sc[g] + 1 > MAXS) ? MAXS : m_sc[g] + 1;
            else       m_sc[g] = (m_sc[g] == 0) ? 0 : m_sc[g] - 1;
            m_sel = g;
            m_tmr = 0;
            if (op[g] && m_sc[g] == WINS) begin
                m_over = 1;
                m_win  = g + 1;
            end
        end else if (m_tmr == DP - 1) begin
            m_tmr = 0;
            m_sel = 1 - m_sel;
        end else begin
            m_tmr++;
        end
    endfunction

    task automatic step(input bit ua, input bit da, input bit ub, input bit db, input bit clr);
        up_a = ua; down_a = da; up_b = ub; down_b = db; clear = clr;
        @(posedge clk);
        mdl_edge(ua, da, ub, db, clr);
        #1;
        check_all();
        up_a = 0; down_a = 0; up_b = 0; down_b = 0; clear = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0);
    endtask

    // Asserts reset between edges so its effect is seen without a clock edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        mdl_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        up_a = 0; down_a = 0; up_b = 0; down_b = 0; clear = 0;
        mdl_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0);

        // Three spaced increments on A.
        repeat (3) begin
            step(1, 0, 0, 0, 0);
            idle(4);
        end
        chk("three_up_a", 8'(score_a), 8'd3);
        chk("three_up_sel", 8'(disp_sel), 8'd0);

        // Simultaneous requests: A first after reset, B first once A was last.
        do_reset();
        step(1, 0, 1, 0, 0);
        chk("conf1_a_k", 8'(score_a), 8'd1);
        chk("conf1_b_k", 8'(score_b), 8'd0);
        idle(1);
        chk("conf1_b_k1", 8'(score_b), 8'd1);
        step(1, 0, 0, 0, 0);
        idle(2);
        step(1, 0, 1, 0, 0);
        chk("conf2_b_k", 8'(score_b), 8'd2);
        chk("conf2_a_k", 8'(score_a), 8'd2);
        idle(1);
        chk("conf2_a_k1", 8'(score_a), 8'd3);

        // Saturation at zero, dropped double press, rotation timing.
        do_reset();
        step(0, 0, 0, 1, 0);
        chk("sat0_b", 8'(score_b), 8'd0);
        chk("sat0_sel", 8'(disp_sel), 8'd1);
        step(1, 1, 0, 0, 0);
        chk("both_a", 8'(score_a), 8'd0);
        idle(DP - 2);
        chk("rot_before", 8'(disp_sel), 8'd1);
        idle(1);
        chk("rot_first", 8'(disp_sel), 8'd0);
        idle(DP - 1);
        chk("rot_mid", 8'(disp_sel), 8'd0);
        idle(1);
        chk("rot_second", 8'(disp_sel), 8'd1);

        // Win by A, then events ignored in OVER.
        do_reset();
        repeat (WINS - 1) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("win_over", 8'(game_over), 8'd1);
        chk("win_code", 8'(winner), 8'd1);
        chk("win_value", 8'(disp_value), 8'(WINS));
        repeat (3) step(0, 0, 1, 0, 0);
        chk("over_b_frozen", 8'(score_b), 8'd0);

        // Clear beats a same-cycle event.
        step(1, 0, 0, 0, 1);
        chk("clr_a", 8'(score_a), 8'd0);
        chk("clr_over", 8'(game_over), 8'd0);
        chk("clr_win", 8'(winner), 8'd0);
        chk("clr_sel", 8'(disp_sel), 8'd0);

        // Random play against the model.
        repeat (3000) begin
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
                     $urandom_range(0, 149) == 0);
            end
        end

        // Reset in the middle of a display period.
        step(0, 1, 0, 0, 1);
        idle(DP / 2);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
